gray_monitor: RTL and testbench

//   Downstream consumer of the gray counter: samples its Output/Overflow each cycle,

---
 rtl/gray_monitor.sv | 141 ++++++++++++++
 tb/tb_gray_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_monitor.sv
// Watches a gray counter's Output/Overflow: decodes the code to binary, counts wraps,
// and latches the first illegal transition seen since reset.
module gray_monitor #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Gray,
    input  logic              Overflow,
    output logic [WIDTH-1:0]  Binary,
    output logic              Step,
    output logic [WRAP_W-1:0] WrapCount,
    output logic              Error,
    output logic [1:0]        ErrCode,
    output logic [1:0]        State
);

    // state | meaning
    // INIT  | first sample after reset, captured without checking
    // TRACK | every change checked as a +1 gray step
    // FAULT | first fault latched, only Reset leaves
    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAXG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_MULTI = 2'b01;
    localparam logic [1:0] CODE_BACK  = 2'b10;
    localparam logic [1:0] CODE_OVF   = 2'b11;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev_gray;
    logic             prev_ovf;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_prev;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] bin_dec;
    logic             multi_bit;
    logic             is_wrap;

    logic             step_nxt;
    logic             wrap_inc;
    logic [1:0]       fault_code;

    assign diff      = Gray ^ prev_gray;
    assign bin_cur   = gray2bin(Gray);
    assign bin_prev  = gray2bin(prev_gray);
    assign bin_inc   = bin_prev + WIDTH'(1);
    assign bin_dec   = bin_prev - WIDTH'(1);
    assign multi_bit = ($countones(diff) > 1);
    assign is_wrap   = (prev_gray == MAXG) && (Gray == '0);

    always_comb begin
        state_nxt  = state;
        step_nxt   = 1'b0;
        wrap_inc   = 1'b0;
        fault_code = CODE_NONE;
        case (state)
            INIT: begin
                state_nxt = TRACK;
            end
            TRACK: begin
                if (diff == '0) begin
                    if (Overflow != prev_ovf) fault_code = CODE_OVF;
                end else if (multi_bit) begin
                    fault_code = CODE_MULTI;
                end else if (bin_cur == bin_inc) begin
                    if (is_wrap) begin
                        if (!Overflow) fault_code = CODE_OVF;
                        else           wrap_inc   = 1'b1;
                    end else if (Overflow != prev_ovf) begin
                        fault_code = CODE_OVF;
                    end
                end else if (bin_cur == bin_dec) begin
                    fault_code = CODE_BACK;
                end else begin
                    // one bit flipped but the code jumped past a neighbour: still a skip
                    fault_code = CODE_MULTI;
                end

                if (fault_code != CODE_NONE) begin
                    state_nxt = FAULT;
                    wrap_inc  = 1'b0;
                end else begin
                    step_nxt  = (diff != '0);
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= INIT;
            prev_gray <= '0;
            prev_ovf  <= 1'b0;
            Binary    <= '0;
            Step      <= 1'b0;
            WrapCount <= '0;
            Error     <= 1'b0;
            ErrCode   <= CODE_NONE;
        end else begin
            state     <= state_nxt;
            prev_gray <= Gray;
            prev_ovf  <= Overflow;
            Binary    <= bin_cur;
            Step      <= step_nxt;
            if (wrap_inc && (WrapCount != '1)) begin
                WrapCount <= WrapCount + WRAP_W'(1);
            end
            if (fault_code != CODE_NONE) begin
                Error   <= 1'b1;
                ErrCode <= fault_code;
            end
        end
    end

    assign State = state;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed and randomized stimulus for gray_monitor, checked each cycle against a
// sequence-index model of the gray counter rules.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Gray;
    logic       Overflow;
    logic [2:0] Binary;
    logic       Step;
    logic [7:0] WrapCount;
    logic       Error;
    logic [1:0] ErrCode;
    logic [1:0] State;

    gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Gray      (Gray),
        .Overflow  (Overflow),
        .Binary    (Binary),
        .Step      (Step),
        .WrapCount (WrapCount),
        .Error     (Error),
        .ErrCode   (ErrCode),
        .State     (State)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: position of a code in the gray sequence i ^ (i >> 1)
    int m_state, m_prev_g, m_bin, m_wrap, m_code;
    bit m_prev_o, m_step, m_err;

    function automatic int seq_index(input int g);
        for (int i = 0; i < 8; i++) begin
            if ((i ^ (i >> 1)) == g) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input bit rst, input int g, input bit o);
        int cur, pv, c;
        bit legal, wrapped;
        if (rst) begin
            m_state = 0; m_prev_g = 0; m_prev_o = 0; m_bin = 0;
            m_step = 0; m_wrap = 0; m_err = 0; m_code = 0;
            return;
        end
        m_bin  = seq_index(g);
        m_step = 0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            cur = seq_index(g);
            pv  = seq_index(m_prev_g);
            c = 0; legal = 0; wrapped = 0;
            if (g == m_prev_g) begin
                if (o != m_prev_o) c = 3;
            end else if (cur == (pv + 1) % 8) begin
                legal = 1;
                if (pv == 7) begin
                    if (!o) c = 3; else wrapped = 1;
                end else if (o != m_prev_o) c = 3;
            end else if (cur == (pv + 7) % 8) begin
                c = 2;
            end else begin
                c = 1;
            end
            if (c != 0) begin
                m_err = 1; m_code = c; m_state = 2;
            end else begin
                m_step = legal;
                if (wrapped && m_wrap < 255) m_wrap++;
            end
        end
        m_prev_g = g;
        m_prev_o = o;
    endtask

    task automatic cycle(input bit rst, input int g, input bit o);
        Reset    = rst;
        Gray     = 3'(g);
        Overflow = o;
        model_update(rst, g, o);
        @(negedge Clk);
        check("Binary",    32'(Binary),    32'(m_bin));
        check("Step",      32'(Step),      32'(m_step));
        check("WrapCount", 32'(WrapCount), 32'(m_wrap));
        check("Error",     32'(Error),     32'(m_err));
        check("ErrCode",   32'(ErrCode),   32'(m_code));
        check("State",     32'(State),     32'(m_state));
    endtask

    // stand-in for the upstream gray counter
    int gen_idx;
    bit gen_ovf;

    function automatic int gen_gray();
        return gen_idx ^ (gen_idx >> 1);
    endfunction

    task automatic do_reset();
        gen_idx = 0;
        gen_ovf = 0;
        cycle(1, 0, 0);
    endtask

    task automatic cnt_step(input bit en);
        if (en) begin
            if (gen_idx == 7) begin
                gen_idx = 0;
                gen_ovf = 1;
            end else begin
                gen_idx++;
            end
        end
        cycle(0, gen_gray(), gen_ovf);
    endtask

    initial begin
        int r;
        Reset = 1'b1; Gray = '0; Overflow = 1'b0;

        // full sequence then one wrap
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 7; i++) cnt_step(1);
        check("no_wrap_yet", 32'(WrapCount), 32'd0);
        cnt_step(1);
        @(negedge Clk);
        check("first_wrap", 32'(WrapCount), 32'd1);

        // enable low: code held, no steps, no fault
        do_reset();
        cycle(0, 0, 0);
        cnt_step(1); cnt_step(1);
        for (int i = 0; i < 3; i++) cnt_step(0);
        check("hold_step", 32'(Step), 32'd0);
        check("hold_err",  32'(Error), 32'd0);
        cnt_step(1);

        // two-bit jump 001 -> 010, then legal steps keep the first code
        do_reset();
        cycle(0, 0, 0);
        cnt_step(1);
        cycle(0, 3'b010, 0);
        check("multi_code", 32'(ErrCode), 32'd1);
        check("multi_state", 32'(State), 32'd2);
        cycle(0, 3'b110, 0);
        cycle(0, 3'b111, 0);
        check("multi_frozen", 32'(ErrCode), 32'd1);

        // wrap without Overflow
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 7; i++) cnt_step(1);
        cycle(0, 0, 0);
        check("ovf_code", 32'(ErrCode), 32'd3);

        // backward 011 -> 001
        do_reset();
        cycle(0, 0, 0);
        cnt_step(1); cnt_step(1);
        cycle(0, 3'b001, 0);
        check("back_code", 32'(ErrCode), 32'd2);

        // Overflow drops without reset
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 9; i++) cnt_step(1);
        cycle(0, gen_gray(), 0);
        check("ovf_drop", 32'(ErrCode), 32'd3);

        // reset mid-count resumes cleanly
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 30; i++) cnt_step(1);
        do_reset();
        check("mid_reset_state", 32'(State), 32'd0);
        cycle(0, 0, 0);
        check("resume_state", 32'(State), 32'd1);
        for (int i = 0; i < 5; i++) cnt_step(1);
        check("resume_err", 32'(Error), 32'd0);

        // saturate the wrap counter
        do_reset();
        cycle(0, 0, 0);
        for (int i = 0; i < 8 * 260; i++) cnt_step(1);
        check("wrap_sat", 32'(WrapCount), 32'd255);

        // randomized mix of counting, holds, glitches and resets
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       do_reset();
            else if (r < 4)  cycle(0, int'($urandom_range(0, 7)), gen_ovf);
            else if (r < 5)  cycle(0, gen_gray(), ~gen_ovf);
            else             cnt_step($urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
